// File: rtl/pb_debounce_rstgen.sv
// N-channel pushbutton conditioner: synchroniser, debouncer, press/release pulses
// and a stretched active-low reset. Define LONG_PRESS_EN to enable long-press pulses.
module pb_debounce_rstgen #(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 9,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 1,
   parameter int RST_CH      = 0,
   parameter int RST_HOLD_W  = 9,
   parameter int LP_W        = 24
) (
   input  logic            SYS_CLK,
   input  logic            reset_n,
   input  logic [N_CH-1:0] pb_raw,
   output logic [N_CH-1:0] db_level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_pulse,
   output logic            rst_out_n
);

   localparam logic                  REL_LVL  = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
   localparam logic [RST_HOLD_W-1:0] HOLD_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [CNT_W-1:0]       cnt_q  [N_CH];
   logic [CNT_W-1:0]       cnt_d  [N_CH];
   logic [N_CH-1:0]        sample;
   logic [N_CH-1:0]        db_d;
   logic [N_CH-1:0]        press_d;
   logic [N_CH-1:0]        release_d;
   logic [RST_HOLD_W-1:0]  hold_q;
   logic                   hold_clr;

   always_ff @(posedge SYS_CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) sync_q[i] <= {SYNC_STAGES{REL_LVL}};
      end else begin
         for (int i = 0; i < N_CH; i++)
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pb_raw[i]};
      end
   end

   // XOR with the released level maps every polarity to 1 = pressed.
   always_comb begin
      for (int i = 0; i < N_CH; i++) sample[i] = sync_q[i][SYNC_STAGES-1] ^ REL_LVL;
   end

   always_comb begin
      db_d      = db_level;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = '0;
         if (sample[i] != db_level[i]) begin
            if (cnt_q[i] != CNT_MAX) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
               db_d[i]      = sample[i];
               press_d[i]   = sample[i];
               release_d[i] = ~sample[i];
            end
         end
      end
   end

   always_ff @(posedge SYS_CLK or negedge reset_n) begin
      if (!reset_n) begin
         db_level      <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         db_level      <= db_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Next level makes rst_out_n fall on the press edge; current level keeps the
   // full HOLD_MAX+1 stretch counted from the release edge.
   assign hold_clr = db_level[RST_CH] | db_d[RST_CH];

   always_ff @(posedge SYS_CLK or negedge reset_n) begin
      if (!reset_n) begin
         hold_q    <= '0;
         rst_out_n <= 1'b0;
      end else if (hold_clr) begin
         hold_q    <= '0;
         rst_out_n <= 1'b0;
      end else if (hold_q != HOLD_MAX) begin
         hold_q    <= hold_q + 1'b1;
         rst_out_n <= 1'b0;
      end else begin
         rst_out_n <= 1'b1;
      end
   end

`ifdef LONG_PRESS_EN
   localparam logic [LP_W-1:0] LP_MAX = '1;

   logic [LP_W-1:0] lp_q [N_CH];

   // Saturation at LP_MAX suppresses repeats until the level drops.
   always_ff @(posedge SYS_CLK or negedge reset_n) begin
      if (!reset_n) begin
         long_pulse <= '0;
         for (int i = 0; i < N_CH; i++) lp_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!db_level[i]) begin
               lp_q[i]       <= '0;
               long_pulse[i] <= 1'b0;
            end else if (lp_q[i] != LP_MAX) begin
               lp_q[i]       <= lp_q[i] + 1'b1;
               long_pulse[i] <= (lp_q[i] == (LP_MAX - 1'b1));
            end else begin
               long_pulse[i] <= 1'b0;
            end
         end
      end
   end
`else
   assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_pb_debounce_rstgen.sv
// Directed bench for pb_debounce_rstgen (N_CH=4, CNT_W=4, RST_HOLD_W=3, LP_W=6).
// Outputs are sampled 1 time unit after each rising edge.
module tb_pb_debounce_rstgen;

   localparam int N_CH = 4;

`ifdef LONG_PRESS_EN
   localparam logic [3:0] LP_CH1 = 4'b0010;
`else
   localparam logic [3:0] LP_CH1 = 4'b0000;
`endif

   logic            SYS_CLK;
   logic            reset_n;
   logic [N_CH-1:0] pb_raw;
   logic [N_CH-1:0] db_level;
   logic [N_CH-1:0] press_pulse;
   logic [N_CH-1:0] release_pulse;
   logic [N_CH-1:0] long_pulse;
   logic            rst_out_n;

   int n_vec = 0;
   int n_err = 0;

   pb_debounce_rstgen #(
      .N_CH(4), .CNT_W(4), .SYNC_STAGES(2), .ACTIVE_LOW(1),
      .RST_CH(0), .RST_HOLD_W(3), .LP_W(6)
   ) dut (
      .SYS_CLK      (SYS_CLK),
      .reset_n      (reset_n),
      .pb_raw       (pb_raw),
      .db_level     (db_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .rst_out_n    (rst_out_n)
   );

   // clock block
   initial SYS_CLK = 1'b0;
   always #5 SYS_CLK = ~SYS_CLK;

   // driver tasks
   task automatic step();
      @(posedge SYS_CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] e_db, input logic [3:0] e_pr,
                            input logic [3:0] e_rl, input logic [3:0] e_lp, input logic e_rst);
      check({tag, " db_level"},      db_level,      e_db);
      check({tag, " press_pulse"},   press_pulse,   e_pr);
      check({tag, " release_pulse"}, release_pulse, e_rl);
      check({tag, " long_pulse"},    long_pulse,    e_lp);
      check({tag, " rst_out_n"},     rst_out_n,     e_rst);
   endtask

   initial begin
      reset_n = 1'b0;
      pb_raw  = 4'hF;
      repeat (3) step();
      check_all("in_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

      // reset release: rst_out_n low for 8 cycles, high from the 8th edge
      reset_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         check_all($sformatf("rst_rel k=%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, k >= 8);
      end

      // clean press on ch1, held 100 cycles: db rises on edge 18, long pulse 63 later
      pb_raw[1] = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         step();
         check_all($sformatf("press1 k=%0d", k),
                   (k >= 18) ? 4'b0010 : 4'b0000,
                   (k == 18) ? 4'b0010 : 4'b0000,
                   4'b0000,
                   (k == 81) ? LP_CH1 : 4'b0000,
                   1'b1);
      end
      pb_raw[1] = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         step();
         check_all($sformatf("rel1 k=%0d", k),
                   (k < 18) ? 4'b0010 : 4'b0000,
                   4'b0000,
                   (k == 18) ? 4'b0010 : 4'b0000,
                   4'b0000, 1'b1);
      end

      // bounce on ch2: two 15-cycle lows split by a 1-cycle high never qualify
      for (int k = 1; k <= 52; k++) begin
         pb_raw[2] = ((k <= 15) || (k >= 17 && k <= 31)) ? 1'b0 : 1'b1;
         step();
         check_all($sformatf("bounce2 k=%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      end

      // simultaneous press/release on ch1 and ch3
      pb_raw = 4'b0101;
      for (int k = 1; k <= 40; k++) begin
         step();
         check_all($sformatf("sim_press k=%0d", k),
                   (k >= 18) ? 4'b1010 : 4'b0000,
                   (k == 18) ? 4'b1010 : 4'b0000,
                   4'b0000, 4'b0000, 1'b1);
      end
      pb_raw = 4'hF;
      for (int k = 1; k <= 22; k++) begin
         step();
         check_all($sformatf("sim_rel k=%0d", k),
                   (k < 18) ? 4'b1010 : 4'b0000,
                   4'b0000,
                   (k == 18) ? 4'b1010 : 4'b0000,
                   4'b0000, 1'b1);
      end

      // reset channel: rst_out_n falls with db_level[0], rises 8 cycles after release
      pb_raw[0] = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         step();
         check_all($sformatf("rstch_press k=%0d", k),
                   (k >= 18) ? 4'b0001 : 4'b0000,
                   (k == 18) ? 4'b0001 : 4'b0000,
                   4'b0000, 4'b0000, k < 18);
      end
      pb_raw[0] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         check_all($sformatf("rstch_rel k=%0d", k),
                   (k < 18) ? 4'b0001 : 4'b0000,
                   4'b0000,
                   (k == 18) ? 4'b0001 : 4'b0000,
                   4'b0000, k >= 26);
      end

      // asynchronous reset while ch3 is held pressed: everything clears at once
      pb_raw[3] = 1'b0;
      repeat (20) step();
      check("pre_async db_level", db_level, 4'b1000);
      #2 reset_n = 1'b0;
      #1 check_all("async_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      pb_raw = 4'hF;
      repeat (3) step();
      reset_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         check_all($sformatf("rst_rel2 k=%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, k >= 8);
      end

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
